zxuno_audio_mixer_sd: RTL

- Parametrised successor to the fixed 5-source mixer (mic/spk/ear/ay1/ay2 to 1-bit audio).
- Mixes NCH unsigned SW-bit sources, time-multiplexed one channel per clock.
- Each channel has a per-channel 4-bit volume and a 2-bit L/R pan, set through ZX-Uno registers (addr/ior/iow).
- Drives two first-order sigma-delta PDM outputs (stereo) and sits beside the turbosound block in the top level.

---
 rtl/zxuno_audio_mixer_sd.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/zxuno_audio_mixer_sd.sv
// Time-multiplexed NCH-channel volume/pan mixer feeding two first-order
// sigma-delta PDM outputs, configured through ZX-Uno registers.
module zxuno_audio_mixer_sd #(
   parameter int          NCH     = 6,
   parameter int          SW      = 8,
   parameter int          DACW    = 10,
   parameter logic [7:0]  REGBASE = 8'h50
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NCH*SW-1:0] ch_in,
   input  logic [7:0]        addr,
   input  logic              ior,
   input  logic              iow,
   input  logic [7:0]        din,
   output logic [7:0]        dout,
   output logic              oe_n,
   output logic              audio_l,
   output logic              audio_r,
   output logic              frame_stb
);

   localparam int CW   = $clog2(NCH);
   localparam int PW   = SW + 4;
   localparam int ACCW = SW + 4 + CW;
   localparam int PHW  = $clog2(NCH + 1);

   logic [5:0]      chreg [NCH];
   logic [1:0]      mreg;
   logic [PHW-1:0]  ph;
   logic [ACCW-1:0] acc_l, acc_r;
   logic [DACW-1:0] lvl_l, lvl_r;
   logic [DACW:0]   sd_l, sd_r;

   logic [SW-1:0]   cur_s;
   logic [5:0]      cur_r;
   logic [PW-1:0]   prod;
   logic [ACCW-1:0] add_l, add_r;
   logic            unused_din;

   assign unused_din = ^din[7:6];

   // Top DACW bits of the accumulator; the sum cannot overflow, so plain truncation.
   function automatic logic [DACW-1:0] trunc_lvl(input logic [ACCW-1:0] a);
      return DACW'(a >> (ACCW - DACW));
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NCH; i++) chreg[i] <= 6'h3F;
         mreg <= 2'b00;
      end else if (iow) begin
         for (int i = 0; i < NCH; i++)
            if (addr == REGBASE + 8'(i)) chreg[i] <= din[5:0];
         if (addr == REGBASE + 8'(NCH)) mreg <= din[1:0];
      end
   end

   always_comb begin
      dout = 8'h00;
      oe_n = 1'b1;
      if (ior) begin
         for (int i = 0; i < NCH; i++)
            if (addr == REGBASE + 8'(i)) begin
               dout = {2'b00, chreg[i]};
               oe_n = 1'b0;
            end
         if (addr == REGBASE + 8'(NCH)) begin
            dout = {6'b000000, mreg};
            oe_n = 1'b0;
         end
      end
   end

   // Stage: select the channel being processed this clock and scale it.
   always_comb begin
      cur_s = '0;
      cur_r = '0;
      for (int i = 0; i < NCH; i++)
         if (ph == PHW'(i)) begin
            cur_s = ch_in[i*SW +: SW];
            cur_r = chreg[i];
         end
   end

   assign prod  = PW'(cur_s) * PW'(cur_r[3:0]);
   assign add_l = cur_r[4] ? ACCW'(prod) : '0;
   assign add_r = cur_r[5] ? ACCW'(prod) : '0;

   // Stage: accumulate per side, latch levels once every NCH+1 clocks.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ph        <= '0;
         acc_l     <= '0;
         acc_r     <= '0;
         lvl_l     <= '0;
         lvl_r     <= '0;
         frame_stb <= 1'b0;
      end else begin
         frame_stb <= 1'b0;
         if (ph == PHW'(NCH)) begin
            ph        <= '0;
            frame_stb <= 1'b1;
            if (mreg[0]) begin
               lvl_l <= '0;
               lvl_r <= '0;
            end else if (mreg[1]) begin
               lvl_l <= trunc_lvl(acc_r);
               lvl_r <= trunc_lvl(acc_l);
            end else begin
               lvl_l <= trunc_lvl(acc_l);
               lvl_r <= trunc_lvl(acc_r);
            end
         end else begin
            ph <= ph + PHW'(1);
            if (ph == '0) begin
               acc_l <= add_l;
               acc_r <= add_r;
            end else begin
               acc_l <= acc_l + add_l;
               acc_r <= acc_r + add_r;
            end
         end
      end
   end

   // Stage: first-order sigma-delta; the carry out is the PDM bit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sd_l <= '0;
         sd_r <= '0;
      end else begin
         sd_l <= {1'b0, sd_l[DACW-1:0]} + {1'b0, lvl_l};
         sd_r <= {1'b0, sd_r[DACW-1:0]} + {1'b0, lvl_r};
      end
   end

   assign audio_l = sd_l[DACW];
   assign audio_r = sd_r[DACW];

endmodule
